// File: rtl/order_book_pkg.sv
// rtl/order_book_pkg.sv - shared command type, order-type codes and arbiter state encoding
package order_book_pkg;

    typedef struct packed {
        logic [31:0] order_id;
        logic [31:0] quantity;
        logic [63:0] price;
        logic [2:0]  order_type;
    } command_t;

    localparam int CMD_W = $bits(command_t);

    localparam logic [2:0] ORD_ADD      = 3'b001;
    localparam logic [2:0] ORD_DECREASE = 3'b010;
    localparam logic [2:0] ORD_DELETE   = 3'b100;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } arb_state_t;

    function automatic logic is_legal_type(input logic [2:0] t);
        return (t == ORD_ADD) || (t == ORD_DECREASE) || (t == ORD_DELETE);
    endfunction

endpackage

// File: rtl/order_book_cmd_arbiter_fifo.sv
// rtl/order_book_cmd_arbiter_fifo.sv - per-stock command FIFO (order_cmd_fifo), registered storage, no bypass
module order_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // A full FIFO refuses the push even if it is popped in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/order_book_cmd_arbiter.sv
// rtl/order_book_cmd_arbiter.sv - round-robin arbiter of per-stock command FIFOs onto one engine; ORDER_ARB_STATS_EN adds counters
module order_book_cmd_arbiter
    import order_book_pkg::*;
#(
    parameter int NUM_STOCKS = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [NUM_STOCKS-1:0]         in_valid,
    output logic [NUM_STOCKS-1:0]         in_ready,
    input  logic [NUM_STOCKS*CMD_W-1:0]   in_cmd,
    output logic                          eng_valid,
    input  logic                          eng_ready,
    output logic [CMD_W-1:0]              eng_cmd,
    output logic [$clog2(NUM_STOCKS)-1:0] eng_stock,
    input  logic                          eng_done,
`ifdef ORDER_ARB_STATS_EN
    output logic [NUM_STOCKS*16-1:0]      stat_issued,
    output logic [15:0]                   stat_illegal,
`endif
    output logic                          busy
);

    localparam int SW = $clog2(NUM_STOCKS);

    arb_state_t          state;
    arb_state_t          state_next;
    logic [SW-1:0]       last_grant;
    logic [NUM_STOCKS-1:0] fifo_full;
    logic [NUM_STOCKS-1:0] fifo_empty;
    logic [NUM_STOCKS-1:0] fifo_pop;
    logic [CMD_W-1:0]    fifo_head [NUM_STOCKS];
    logic                grant_found;
    logic [SW-1:0]       grant_idx;
    logic [SW-1:0]       cand_idx;
    command_t            grant_cmd;
    logic                grant_legal;
    logic                grant_take;

    for (genvar g = 0; g < NUM_STOCKS; g++) begin : g_fifo
        order_cmd_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (CMD_W)
        ) u_fifo (
            .clk       (clk),
            .resetn    (resetn),
            .push      (in_valid[g]),
            .pop       (fifo_pop[g]),
            .push_data (in_cmd[g*CMD_W +: CMD_W]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g]),
            .head      (fifo_head[g])
        );
    end

    assign in_ready = ~fifo_full;

    // Search starts one past last_grant so the previous winner has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int k = 1; k <= NUM_STOCKS; k++) begin
            cand_idx = SW'((int'(last_grant) + k) % NUM_STOCKS);
            if (!grant_found && !fifo_empty[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    assign grant_cmd   = command_t'(fifo_head[grant_idx]);
    assign grant_legal = is_legal_type(grant_cmd.order_type);
    assign grant_take  = (state == IDLE) && grant_found;

    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found && grant_legal) state_next = ISSUE;
            ISSUE:   if (eng_ready) state_next = WAIT;
            WAIT:    if (eng_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_pop = '0;
        if (grant_take) fifo_pop[grant_idx] = 1'b1;
        eng_valid = (state == ISSUE);
        busy      = (state != IDLE) || !(&fifo_empty);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_grant <= SW'(NUM_STOCKS - 1);
            eng_cmd    <= '0;
            eng_stock  <= '0;
        end else if (grant_take) begin
            last_grant <= grant_idx;
            if (grant_legal) begin
                eng_cmd   <= grant_cmd;
                eng_stock <= grant_idx;
            end
        end
    end

`ifdef ORDER_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stat_issued  <= '0;
            stat_illegal <= '0;
        end else begin
            if (eng_valid && eng_ready)
                stat_issued[eng_stock*16 +: 16] <= stat_issued[eng_stock*16 +: 16] + 16'd1;
            if (grant_take && !grant_legal)
                stat_illegal <= stat_illegal + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_order_book_cmd_arbiter.sv
// tb/tb_order_book_cmd_arbiter.sv - directed and randomized checks of order_book_cmd_arbiter; ORDER_ARB_STATS_EN checks counters
module tb_order_book_cmd_arbiter;
    import order_book_pkg::*;

    localparam int NS = 4;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [NS-1:0]      in_valid = '0;
    logic [NS-1:0]      in_ready;
    logic [NS*CMD_W-1:0] in_cmd = '0;
    logic               eng_valid;
    logic               eng_ready = 1'b0;
    logic [CMD_W-1:0]   eng_cmd;
    logic [1:0]         eng_stock;
    logic               eng_done = 1'b0;
    logic               busy;
`ifdef ORDER_ARB_STATS_EN
    logic [NS*16-1:0]   stat_issued;
    logic [15:0]        stat_illegal;
`endif

    order_book_cmd_arbiter #(.NUM_STOCKS(NS), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_cmd    (in_cmd),
        .eng_valid (eng_valid),
        .eng_ready (eng_ready),
        .eng_cmd   (eng_cmd),
        .eng_stock (eng_stock),
        .eng_done  (eng_done),
`ifdef ORDER_ARB_STATS_EN
        .stat_issued  (stat_issued),
        .stat_illegal (stat_illegal),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    command_t mq [NS][$];
    int       exp_issued [NS];
    int       exp_ill;
    int       lg;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic command_t mk(input logic [31:0] id, input logic [31:0] qty,
                                    input logic [63:0] px, input logic [2:0] t);
        command_t c;
        c.order_id = id; c.quantity = qty; c.price = px; c.order_type = t;
        return c;
    endfunction

    function automatic bit legal_t(input logic [2:0] t);
        return t == 3'b001 || t == 3'b010 || t == 3'b100;
    endfunction

    function automatic command_t rand_cmd(input bit allow_bad);
        command_t   c;
        logic [2:0] good [3] = '{3'b001, 3'b010, 3'b100};
        logic [2:0] bad  [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        c = mk($urandom, $urandom, {$urandom, $urandom}, 3'b001);
        if (allow_bad && $urandom_range(0, 3) == 0) c.order_type = bad[$urandom_range(0, 4)];
        else                                          c.order_type = good[$urandom_range(0, 2)];
        return c;
    endfunction

    task automatic do_reset();
        resetn = 1'b0; in_valid = '0; eng_ready = 1'b0; eng_done = 1'b0;
        tick(); tick();
        resetn = 1'b1;
        for (int s = 0; s < NS; s++) begin mq[s].delete(); exp_issued[s] = 0; end
        exp_ill = 0;
        lg = NS - 1;
    endtask

    task automatic push(input int s, input command_t c);
        in_valid[s] = 1'b1;
        in_cmd[s*CMD_W +: CMD_W] = c;
        tick();
        in_valid[s] = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int i = 0; i < 60 && !eng_valid; i++) tick();
        check({tag, "_timeout"}, eng_valid, 1'b1);
    endtask

    task automatic serve(input int s, input command_t c, input int rdly, input int ddly, input string tag);
        wait_valid(tag);
        check({tag, "_stock"}, eng_stock, s);
        check({tag, "_cmd"}, eng_cmd, c);
        for (int d = 0; d < rdly; d++) begin
            tick();
            check({tag, "_hold"}, {eng_valid, eng_stock, eng_cmd}, {1'b1, 2'(s), c});
        end
        eng_ready = 1'b1; tick(); eng_ready = 1'b0;
        check({tag, "_accept"}, eng_valid, 1'b0);
        for (int d = 0; d < ddly; d++) tick();
        eng_done = 1'b1; tick(); eng_done = 1'b0;
    endtask

    initial begin
        command_t c, b;
        command_t c4 [4];
        int       pick;
        bit       found;

        // Reset state
        do_reset();
        check("rst_valid", eng_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 4'hF);
        check("rst_cmd", eng_cmd, '0);
        check("rst_stock", eng_stock, 2'd0);

        // Single command latency and field integrity
        eng_ready = 1'b1;
        c = mk(32'h10, 32'd5, 64'd1000, 3'b001);
        push(2, c);
        check("t1_nobypass", eng_valid, 1'b0);
        check("t1_busy", busy, 1'b1);
        tick();
        check("t1_valid", eng_valid, 1'b1);
        check("t1_stock", eng_stock, 2'd2);
        check("t1_cmd", eng_cmd, c);
        tick();
        check("t1_accepted", eng_valid, 1'b0);
        tick(); tick();
        eng_done = 1'b1; tick(); eng_done = 1'b0;
        eng_ready = 1'b0;
        check("t1_idle_busy", busy, 1'b0);

        // Simultaneous pushes on all stocks come out 0,1,2,3
        do_reset();
        for (int s = 0; s < NS; s++) begin
            c4[s] = mk(32'h100 + s, s + 1, 64'd500 + s, 3'b001);
            in_cmd[s*CMD_W +: CMD_W] = c4[s];
        end
        in_valid = '1; tick(); in_valid = '0;
        for (int s = 0; s < NS; s++) serve(s, c4[s], 0, 0, $sformatf("t2_%0d", s));

        // Engine back-pressure holds the command stable
        do_reset();
        c = mk(32'h33, 32'd9, 64'd77, 3'b010);
        push(1, c);
        serve(1, c, 5, 0, "t3");

        // FIFO full with engine stalled; drain order preserved
        do_reset();
        b = mk(32'hB0, 1, 1, 3'b100);
        push(0, b);
        wait_valid("t4_blk");
        for (int j = 0; j < 5; j++) begin
            c = mk(32'h40 + j, j, j, 3'b001);
            if (j < 4) c4[j] = c;
            check($sformatf("t4_ready_%0d", j), in_ready[1], j < 4);
            push(1, c);
        end
        serve(0, b, 0, 0, "t4_b");
        for (int j = 0; j < 4; j++) serve(1, c4[j], 0, 0, $sformatf("t4_d%0d", j));
        tick(); tick();
        check("t4_drained", {busy, eng_valid}, 2'b00);

        // Illegal type discarded
        do_reset();
        push(0, mk(32'h6, 1, 1, 3'b011));
        c = mk(32'h7, 2, 2, 3'b001);
        push(0, c);
        serve(0, c, 0, 0, "t5");
        tick(); tick(); tick();
        check("t5_no_more", {busy, eng_valid}, 2'b00);
`ifdef ORDER_ARB_STATS_EN
        check("t5_stat_illegal", stat_illegal, 16'd1);
        check("t5_stat_issued0", stat_issued[15:0], 16'd1);
`endif

        // Reset in WAIT with commands queued
        do_reset();
        push(0, b);
        wait_valid("t6_blk");
        eng_ready = 1'b1; tick(); eng_ready = 1'b0;
        push(1, mk(32'h61, 1, 1, 3'b001));
        push(2, mk(32'h62, 1, 1, 3'b001));
        resetn = 1'b0; tick(); resetn = 1'b1;
        check("t6_valid", eng_valid, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_ready", in_ready, 4'hF);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t6_quiet", eng_valid, 1'b0);
        end

        // Randomized rounds against the queue model
        do_reset();
        for (int r = 0; r < 15; r++) begin
            int s;
            int np;
            s = $urandom_range(0, NS - 1);
            b = rand_cmd(1'b0);
            push(s, b);
            wait_valid("rnd_blk");
            check("rnd_blk_stock", eng_stock, s);
            check("rnd_blk_cmd", eng_cmd, b);
            lg = s;
            np = $urandom_range(4, 20);
            for (int j = 0; j < np; j++) begin
                int  ps;
                bit  er;
                ps = $urandom_range(0, NS - 1);
                c  = rand_cmd(1'b1);
                er = mq[ps].size() < 4;
                check("rnd_in_ready", in_ready[ps], er);
                push(ps, c);
                if (er) mq[ps].push_back(c);
            end
            check("rnd_held", {eng_valid, eng_stock, eng_cmd}, {1'b1, 2'(s), b});
            eng_ready = 1'b1; tick(); eng_ready = 1'b0;
            exp_issued[s]++;
            for (int d = 0; d < int'($urandom_range(0, 2)); d++) tick();
            eng_done = 1'b1; tick(); eng_done = 1'b0;
            forever begin
                found = 1'b0;
                pick  = 0;
                for (int k = 1; k <= NS; k++) begin
                    int cand;
                    cand = (lg + k) % NS;
                    if (!found && mq[cand].size() > 0) begin found = 1'b1; pick = cand; end
                end
                if (!found) break;
                c  = mq[pick].pop_front();
                lg = pick;
                if (!legal_t(c.order_type)) begin
                    exp_ill++;
                    continue;
                end
                serve(pick, c, $urandom_range(0, 2), $urandom_range(0, 2), "rnd");
                exp_issued[pick]++;
            end
            for (int i = 0; i < 6; i++) tick();
            check("rnd_idle", {busy, eng_valid}, 2'b00);
        end
`ifdef ORDER_ARB_STATS_EN
        check("rnd_stat_illegal", stat_illegal, 16'(exp_ill));
        for (int s = 0; s < NS; s++)
            check($sformatf("rnd_stat_issued%0d", s), stat_issued[s*16 +: 16], 16'(exp_issued[s]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
